// File: rtl/pattern_scan_pkg.sv
// Shared types, default geometry and helpers for the program-3 pattern-count sequencer.
package pattern_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LDPAT,
    SCAN,
    WR_CTB,
    WR_CTO,
    WR_CTS,
    DONE
  } state_t;

  localparam int DEF_N_BYTES  = 32;
  localparam int DEF_PAT_ADDR = 32;
  localparam int DEF_RES_ADDR = 33;
  localparam int DEF_AW       = 8;
  localparam int DEF_CW       = 8;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/pattern_window_cmp.sv
// Compares the 5-bit pattern against the four within-byte windows of cur and the
// four windows that straddle the prev/cur byte boundary.
module pattern_window_cmp
  import pattern_scan_pkg::*;
(
  input  logic [4:0] pat,
  input  logic [7:0] prev,
  input  logic [7:0] cur,
  input  logic       first,
  output logic [2:0] in_cnt,
  output logic       any_in,
  output logic [2:0] x_cnt
);

  logic [15:0] w_pair;
  logic [3:0]  w_in_hit;
  logic [3:0]  w_x_hit;

  assign w_pair = {prev, cur};

  assign w_in_hit = {cur[7:3] == pat, cur[6:2] == pat,
                     cur[5:1] == pat, cur[4:0] == pat};

  // Each crossing window takes at least one bit from both bytes.
  assign w_x_hit = {w_pair[11:7] == pat, w_pair[10:6] == pat,
                    w_pair[9:5]  == pat, w_pair[8:4]  == pat};

  assign in_cnt = popcount4(w_in_hit);
  assign any_in = |w_in_hit;
  assign x_cnt  = first ? 3'd0 : popcount4(w_x_hit);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Sequencer that owns the data-memory port: loads the pattern, scans N_BYTES bytes,
// writes the three match counts back and then signals done.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int N_BYTES  = DEF_N_BYTES,
  parameter int PAT_ADDR = DEF_PAT_ADDR,
  parameter int RES_ADDR = DEF_RES_ADDR,
  parameter int AW       = DEF_AW,
  parameter int CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic          busy,
  output logic          done
);

  localparam int IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BYTES - 1);

  if (((8 * N_BYTES - 4) >> CW) != 0) begin : g_cw_too_small
    $error("pattern_scan_ctrl: CW cannot hold 8*N_BYTES-4");
  end

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_idx;
  logic [4:0]      r_pat;
  logic [7:0]      r_prev;
  logic [CW-1:0]   r_ctb;
  logic [CW-1:0]   r_cto;
  logic [CW-1:0]   r_cts;
  logic [2:0]      w_in_cnt;
  logic            w_any_in;
  logic [2:0]      w_x_cnt;
  logic            w_last;

  assign w_last = (r_idx == LAST_IDX);

  pattern_window_cmp u_cmp (
    .pat    (r_pat),
    .prev   (r_prev),
    .cur    (mem_rd_data),
    .first  (r_idx == '0),
    .in_cnt (w_in_cnt),
    .any_in (w_any_in),
    .x_cnt  (w_x_cnt)
  );

  // NOTE: reset is sampled on the clock edge only; a reset pulse shorter than a
  // cycle that misses a posedge has no effect.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output and w_next gets a default before the case so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_next      = r_state;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = LDPAT;
      LDPAT: begin
        busy     = 1'b1;
        mem_addr = AW'(PAT_ADDR);
        w_next   = SCAN;
      end
      SCAN: begin
        busy     = 1'b1;
        mem_addr = AW'(r_idx);
        if (w_last) w_next = WR_CTB;
      end
      WR_CTB: begin
        busy        = 1'b1;
        mem_wr_en   = 1'b1;
        mem_addr    = AW'(RES_ADDR);
        mem_wr_data = 8'(r_ctb);
        w_next      = WR_CTO;
      end
      WR_CTO: begin
        busy        = 1'b1;
        mem_wr_en   = 1'b1;
        mem_addr    = AW'(RES_ADDR + 1);
        mem_wr_data = 8'(r_cto);
        w_next      = WR_CTS;
      end
      WR_CTS: begin
        busy        = 1'b1;
        mem_wr_en   = 1'b1;
        mem_addr    = AW'(RES_ADDR + 2);
        mem_wr_data = 8'(r_cts);
        w_next      = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_next = LDPAT;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx  <= '0;
      r_pat  <= '0;
      r_prev <= '0;
      r_ctb  <= '0;
      r_cto  <= '0;
      r_cts  <= '0;
    end else begin
      case (r_state)
        LDPAT: begin
          r_pat  <= mem_rd_data[7:3];
          r_idx  <= '0;
          r_prev <= '0;
          r_ctb  <= '0;
          r_cto  <= '0;
          r_cts  <= '0;
        end
        SCAN: begin
          r_ctb  <= r_ctb + CW'(w_in_cnt);
          r_cto  <= r_cto + CW'(w_any_in);
          r_cts  <= r_cts + CW'(w_in_cnt) + CW'(w_x_cnt);
          r_prev <= mem_rd_data;
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: memory model, timeline-level reference of the port
// behaviour and a bit-string reference of the three counts.
module tb_pattern_scan_ctrl;

  localparam int N     = 32;
  localparam int PAT_A = 32;
  localparam int RES_A = 33;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic       busy;
  logic       done;

  logic [7:0] dm_in [256];
  logic [7:0] wmem  [256];
  int         n_wr = 0;
  int         n_vec = 0;
  int         n_err = 0;

  // Cycles since the accepting edge: 0 idle, 1..36 busy, 37 done.
  int         phase = 0;
  bit         model_ok = 1'b0;
  int         e_ctb, e_cto, e_cts;

  always #5 clk = ~clk;

  pattern_scan_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .done        (done)
  );

  assign mem_rd_data = dm_in[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      wmem[mem_addr] <= mem_wr_data;
      n_wr           <= n_wr + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Counts 5-bit windows over the 256-bit string, byte 0 most significant.
  function automatic void ref_counts(output int ctb, output int cto, output int cts);
    logic [255:0] s;
    logic [4:0]   pat;
    logic [31:0]  hit;
    pat = dm_in[PAT_A][7:3];
    for (int i = 0; i < N; i++) s[255 - 8 * i -: 8] = dm_in[i];
    ctb = 0;
    cts = 0;
    hit = '0;
    for (int p = 0; p <= 8 * N - 5; p++) begin
      if (s[255 - p -: 5] == pat) begin
        cts++;
        if ((p % 8) <= 3) begin
          ctb++;
          hit[p / 8] = 1'b1;
        end
      end
    end
    cto = $countones(hit);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      phase    = 0;
      model_ok = 1'b1;
    end else if ((phase == 0 || phase == 37) && start) begin
      phase = 1;
      ref_counts(e_ctb, e_cto, e_cts);
    end else if (phase >= 1 && phase <= 36) begin
      phase++;
    end
  end

  always @(negedge clk) begin
    int ea;
    if (model_ok) begin
      if (phase == 1)                     ea = PAT_A;
      else if (phase >= 2 && phase <= 33) ea = phase - 2;
      else if (phase >= 34 && phase <= 36) ea = RES_A + phase - 34;
      else                                ea = 0;
      check("busy", busy, 32'(phase >= 1 && phase <= 36));
      check("done", done, 32'(phase == 37));
      check("wr_en", mem_wr_en, 32'(phase >= 34 && phase <= 36));
      check("addr", mem_addr, ea);
      if (phase == 34) check("wdata_ctb", mem_wr_data, e_ctb);
      if (phase == 35) check("wdata_cto", mem_wr_data, e_cto);
      if (phase == 36) check("wdata_cts", mem_wr_data, e_cts);
      if (phase == 0)  check("idle_wdata", mem_wr_data, 0);
    end
  end

  task automatic load(input logic [4:0] pat, input bit rnd, input logic [7:0] byte_v);
    dm_in[PAT_A] = {pat, 3'($urandom)};
    for (int i = 0; i < N; i++) dm_in[i] = rnd ? 8'($urandom) : byte_v;
  endtask

  task automatic wait_done(inout int lat);
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(output int lat, output int nw);
    int w0;
    w0 = n_wr;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    wait_done(lat);
    nw = n_wr - w0;
  endtask

  task automatic check_results(input string tag, input int ctb, input int cto, input int cts);
    check({tag, "_dm33"}, wmem[RES_A], ctb);
    check({tag, "_dm34"}, wmem[RES_A + 1], cto);
    check({tag, "_dm35"}, wmem[RES_A + 2], cts);
  endtask

  initial begin
    int lat, nw, a, b, c, k, w0;
    logic [7:0] s0, s1, s2;
    for (int i = 0; i < 256; i++) dm_in[i] = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    reset = 1'b1;

    load(5'b11111, 1'b0, 8'hFF);
    run(lat, nw);
    check("ff_latency", lat, 36);
    check("ff_writes", nw, 3);
    check_results("ff", 128, 32, 252);

    load(5'b11111, 1'b0, 8'h00);
    run(lat, nw);
    check("zero_latency", lat, 36);
    check("zero_writes", nw, 3);
    check_results("zero", 0, 0, 0);

    load(5'b10101, 1'b0, 8'h55);
    run(lat, nw);
    check("x55_writes", nw, 3);
    check_results("x55", 64, 32, 126);

    for (int r = 0; r < 100; r++) begin
      load(5'($urandom), 1'b1, 8'h00);
      if (r % 4 == 0)
        for (int i = 0; i < N; i++) dm_in[i] = {dm_in[PAT_A][7:3], 3'($urandom)};
      run(lat, nw);
      ref_counts(a, b, c);
      check("rnd_latency", lat, 36);
      check("rnd_writes", nw, 3);
      check_results("rnd", a, b, c);
    end

    // Abort during the scan at byte 10.
    load(5'($urandom), 1'b1, 8'h00);
    s0 = wmem[RES_A];
    s1 = wmem[RES_A + 1];
    s2 = wmem[RES_A + 2];
    w0 = n_wr;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(busy && mem_addr == 8'd10) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("abort_reached_i10", 32'(busy && mem_addr == 8'd10), 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (40) @(negedge clk);
    check("abort_no_writes", n_wr - w0, 0);
    check("abort_dm33_kept", wmem[RES_A], s0);
    check("abort_dm34_kept", wmem[RES_A + 1], s1);
    check("abort_dm35_kept", wmem[RES_A + 2], s2);
    run(lat, nw);
    ref_counts(a, b, c);
    check("after_abort_latency", lat, 36);
    check_results("after_abort", a, b, c);

    // A start pulse while busy must not disturb the run.
    load(5'($urandom), 1'b1, 8'h00);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    repeat (10) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    wait_done(lat);
    ref_counts(a, b, c);
    check("busy_start_latency", lat, 36);
    check_results("busy_start", a, b, c);

    // Start held high in DONE restarts and rewrites identical results.
    s0 = wmem[RES_A];
    s1 = wmem[RES_A + 1];
    s2 = wmem[RES_A + 2];
    w0 = n_wr;
    start = 1'b1;
    @(negedge clk);
    check("held_done_drop", done, 0);
    lat = 0;
    @(negedge clk);
    lat++;
    start = 1'b0;
    wait_done(lat);
    check("held_latency", lat, 36);
    check("held_writes", n_wr - w0, 3);
    check("held_dm33_same", wmem[RES_A], s0);
    check("held_dm34_same", wmem[RES_A + 1], s1);
    check("held_dm35_same", wmem[RES_A + 2], s2);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
